// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
// The slice width is fixed at 4 bits; the pass count follows from the operand width.
package nibble_serial_add_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nib(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the controller (slave).
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, op_sub, carry_in, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, carry_in, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, busy
    );
endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice; c3 is the carry into the top bit,
// which lets the caller derive signed overflow as cout ^ c3.
module nibble_add_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);
    logic [4:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign cout = c_s[4];
    assign c3   = c_s[3];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed by cycling one 4-bit adder slice over WIDTH/4 passes,
// least-significant nibble first, with the carry held in a register between passes.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    nibble_serial_add_ctrl_if.slave  bus
);
    localparam int NIB   = calc_nib(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_r;
    state_e             next_state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               cy_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_out_r;
    logic               overflow_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               in_ready_r;
    logic               accept_s;
    logic               step_s;
    logic               last_s;
    logic [3:0]         sum_s;
    logic               cout_s;
    logic               c3_s;

    nibble_add_slice u_slice (
        .a    (a_r[SLICE_W-1:0]),
        .b    (b_r[SLICE_W-1:0]),
        .cin  (cy_r),
        .s    (sum_s),
        .cout (cout_s),
        .c3   (c3_s)
    );

    // Next-state decode and per-cycle datapath enables.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = (idx_r == IDX_W'(NIB - 1));
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, status flags, operand shift registers, carry and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cy_r        <= 1'b0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == IDLE);
            busy_r      <= (next_state_s != IDLE);
            out_valid_r <= (next_state_s == DONE);
            if (accept_s) begin
                a_r   <= bus.op_a;
                b_r   <= bus.op_sub ? ~bus.op_b : bus.op_b;
                cy_r  <= bus.carry_in ^ bus.op_sub;
                idx_r <= '0;
            end else if (step_s) begin
                a_r      <= a_r >> SLICE_W;
                b_r      <= b_r >> SLICE_W;
                cy_r     <= cout_s;
                result_r <= {sum_s, result_r[WIDTH-1:SLICE_W]};
                idx_r    <= idx_r + IDX_W'(1);
                if (last_s) begin
                    carry_out_r <= cout_s;
                    overflow_r  <= cout_s ^ c3_s;
                end else begin
                    carry_out_r <= carry_out_r;
                    overflow_r  <= overflow_r;
                end
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // in_ready must read low during the reset cycle itself, so the register is gated by rst.
    assign bus.in_ready  = in_ready_r & ~rst;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
    assign bus.busy      = busy_r;
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle controller that computes WIDTH-bit add/subtract by sequencing one 4-bit ripple-carry adder slice over WIDTH/4 cycles, LSB nibble first.
- Carry is held in a register between cycles.
- Valid/ready handshake on both sides; trades latency for area in datapaths that need wide arithmetic from a single narrow adder.

Parameters:
- WIDTH, 16, operand/result width; multiple of 4, minimum 8.
- NIB, derived as WIDTH/4, number of slice passes (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request presents operands.
- in_ready  output  1  controller can accept a request.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_sub  input  1  0 = A+B+carry_in; 1 = A-B-borrow (A + ~B + ~carry_in).
- carry_in  input  1  carry-in (add) or borrow-in (sub).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  raw carry out of the MSB slice (for sub, 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. All state is updated only on the rising edge of clk.
- States:
  - IDLE: in_ready=1 (gated low while rst=1).
  - RUN: nibble index idx counts 0..NIB-1.
  - DONE: out_valid=1.
- Reset values: state IDLE, in_ready 1 once rst is low, out_valid 0, busy 0, result 0, carry_out 0, overflow 0, idx 0.
- IDLE to RUN on in_valid & in_ready. On that edge the controller latches:
  - a_reg = op_a.
  - b_reg = op_sub ? ~op_b : op_b.
  - carry register = carry_in ^ op_sub.
  - idx = 0.
- RUN, each cycle:
  - Slice inputs: a_reg[3:0], b_reg[3:0], carry register.
  - Sum nibble shifts into result from the top (result >> 4, sum placed in [WIDTH-1:WIDTH-4]).
  - a_reg and b_reg shift right by 4.
  - Carry register takes the slice carry-out.
  - idx increments.
- On the edge where idx = NIB-1, go to DONE. That edge also sets:
  - carry_out = slice carry-out.
  - overflow = slice carry-out XOR carry into bit 3 of the final slice, i.e. a3 ^ b3 ^ s3 of that slice.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
- DONE:
  - result, carry_out and overflow stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, go to IDLE; out_valid drops next cycle.
  - No same-cycle re-accept: in_ready is 0 throughout RUN and DONE.
- Inputs on op_*, carry_in and in_valid are ignored outside IDLE. Operands need only be stable on the accepting edge.
- Reset mid-operation (RUN or DONE): abort and return to IDLE. out_valid is never asserted for the aborted request, and every output returns to its reset value.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - carry_out is bit WIDTH of A + B_eff + cin_eff.
- Simultaneous rst and in_valid: reset wins, nothing is accepted.

Decomposition:
- Shared package holds:
  - SLICE_W = 4.
  - State enum {IDLE, RUN, DONE} with 2-bit encoding.
  - A function computing NIB from WIDTH.
- One sub-module, nibble_add_slice: combinational 4-bit ripple adder with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout, c3 (carry into bit 3, used for overflow).
- Controller FSM, shift registers and counter live in the top module.

Test Plan:
- Add, WIDTH=16: 0x1234 + 0x0FFF, carry_in=0 -> result 0x2233, carry_out 0, overflow 0; out_valid exactly 4 edges after accept.
- Unsigned wrap: 0xFFFF + 0x0001 -> 0x0000, carry_out 1, overflow 0.
- Carry-in across nibbles and signed overflow:
  - 0x00FF + 0x0000, carry_in=1 -> 0x0100.
  - 0x7FFF + 0x0001 -> 0x8000, carry_out 0, overflow 1.
- Subtract: 0x0005 - 0x0007, op_sub=1, carry_in=0 -> 0xFFFE, carry_out 0, overflow 0.
- Borrow-in: 0x8000 - 0x0001 with carry_in=1 -> 0x7FFE, overflow 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while toggling op_a, op_b and in_valid.
  - result stays constant, in_ready stays 0.
  - Raising out_ready returns to IDLE; in_ready=1 the next cycle.
  - The following request computes correctly.
- Reset abort: assert rst for 1 cycle while idx=2.
  - out_valid never rises; all outputs return to reset values.
  - A new 0x0001 + 0x0001 completes with 0x0002 after 4 cycles.
